// File: rtl/cube_seq_if.sv
// Bundle between the cube sequencing controller and the agent that drives it.
// Strobe semantics: load is a single-cycle completion strobe sampled on the
// rising clock edge; match is meaningful only in the same cycle as load while
// the controller is in CHECK. run is a level request; abort is a synchronous
// one-cycle (or longer) request. There is no back-pressure: every load seen in
// CHANGE/CHECK is consumed in that cycle.
interface cube_seq_if #(
  parameter int IW = 4
);
  logic          run;
  logic          load;
  logic          match;
  logic          abort;
  logic [IW-1:0] iter_limit;

  logic [2:0]    q;
  logic          change_en;
  logic          check_en;
  logic          busy;
  logic          done;
  logic          fail;
  logic [IW-1:0] iter_cnt;

  // Agent side: drives requests, observes controller status.
  modport master (
    output run, load, match, abort, iter_limit,
    input  q, change_en, check_en, busy, done, fail, iter_cnt
  );

  // Controller side.
  modport slave (
    input  run, load, match, abort, iter_limit,
    output q, change_en, check_en, busy, done, fail, iter_cnt
  );
endinterface

// File: rtl/cube_seq_ctrl.sv
// Change/check iteration sequencer: alternates CHANGE and CHECK phases until a
// check matches, the iteration limit runs out, a phase times out, or abort.
// The state register is exported on q so checkers can observe the FSM.
module cube_seq_ctrl #(
  parameter int IW      = 4,
  parameter int TW      = 8,
  parameter int TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  cube_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHANGE = 3'd1,
    S_CHECK  = 3'd2,
    S_FIN    = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  localparam bit            TO_EN        = (TIMEOUT != 0);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
  localparam logic [IW:0]   ITER_ONE     = (IW+1)'(1);
  localparam logic [IW-1:0] LIMIT_ONE    = IW'(1);

  state_e        state_q, state_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [IW-1:0] limit_q, limit_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fail_q, fail_d;

  // Counter compare is done one bit wider so iter+1 can never alias the limit.
  logic [IW:0]   iter_next;
  logic          timeout_hit;

  // Next-state and next-datapath computation; priority abort > load > timeout.
  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    limit_d     = limit_q;
    timer_d     = timer_q;
    fail_d      = fail_q;
    iter_next   = {1'b0, iter_q} + ITER_ONE;
    timeout_hit = TO_EN && (timer_q == TIMEOUT_LAST) && !bus.load;

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      iter_d  = '0;
      timer_d = '0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Abort while idle wins over run: stay idle.
          if (bus.run && !bus.abort) begin
            state_d = S_CHANGE;
            iter_d  = '0;
            limit_d = (bus.iter_limit == '0) ? LIMIT_ONE : bus.iter_limit;
            timer_d = '0;
            fail_d  = 1'b0;
          end
        end
        S_CHANGE: begin
          if (bus.load) begin
            state_d = S_CHECK;
            timer_d = '0;
          end else if (timeout_hit) begin
            state_d = S_ERR;
            timer_d = '0;
            fail_d  = 1'b1;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        S_CHECK: begin
          if (bus.load) begin
            timer_d = '0;
            if (bus.match) begin
              state_d = S_FIN;
              fail_d  = 1'b0;
            end else begin
              iter_d = iter_next[IW-1:0];
              if (iter_next >= {1'b0, limit_q}) begin
                state_d = S_FIN;
                fail_d  = 1'b1;
              end else begin
                state_d = S_CHANGE;
              end
            end
          end else if (timeout_hit) begin
            state_d = S_ERR;
            timer_d = '0;
            fail_d  = 1'b1;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        S_FIN, S_ERR: begin
          // Result is held for the requester until it drops run.
          if (!bus.run) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          iter_d  = '0;
          timer_d = '0;
          fail_d  = 1'b0;
        end
      endcase
    end
  end

  // All controller state; async reset matches the power-on condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      limit_q <= LIMIT_ONE;
      timer_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      limit_q <= limit_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
    end
  end

  // Status decodes of the state register.
  assign bus.q         = state_q;
  assign bus.change_en = (state_q == S_CHANGE);
  assign bus.check_en  = (state_q == S_CHECK);
  assign bus.busy      = (state_q == S_CHANGE) || (state_q == S_CHECK);
  assign bus.done      = (state_q == S_FIN);
  assign bus.fail      = fail_q;
  assign bus.iter_cnt  = iter_q;

endmodule

// File: tb/tb_cube_seq_ctrl.sv
// Directed bench for cube_seq_ctrl: reset, match/no-match runs, limit
// exhaustion, abort, timeout boundary and mid-run asynchronous reset.
module tb_cube_seq_ctrl;

  localparam int IW = 4;
  localparam int TW = 8;
  localparam int TIMEOUT = 200;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cube_seq_if #(.IW(IW)) bus ();

  cube_seq_ctrl #(.IW(IW), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Scoreboard
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_load(input logic m);
    bus.load  = 1'b1;
    bus.match = m;
    tick();
    bus.load  = 1'b0;
    bus.match = 1'b0;
  endtask

  initial begin
    bus.run        = 1'b0;
    bus.load       = 1'b0;
    bus.match      = 1'b0;
    bus.abort      = 1'b0;
    bus.iter_limit = 4'd3;

    // Reset state
    ticks(2);
    chk("rst_q", bus.q, 0);
    chk("rst_iter", bus.iter_cnt, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_en", {bus.change_en, bus.check_en}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", bus.q, 0);

    // Limit 3, matches 0,0,1 -> q 1,2,1,2,1,2,3
    exp_q = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd3};
    bus.run = 1'b1;
    tick();
    chk("seq_q0", bus.q, exp_q.pop_front());
    chk("seq_change_en", bus.change_en, 1);
    chk("seq_busy", bus.busy, 1);
    for (int i = 0; i < 6; i++) begin
      pulse_load(i == 5);
      chk($sformatf("seq_q%0d", i + 1), bus.q, exp_q.pop_front());
      if (i == 0) chk("seq_check_en", bus.check_en, 1);
    end
    chk("seq_done", bus.done, 1);
    chk("seq_fail", bus.fail, 0);
    chk("seq_iter", bus.iter_cnt, 2);
    ticks(2);
    chk("fin_hold", bus.q, 3);
    pulse_load(1'b0);
    chk("fin_load_ignored", bus.q, 3);
    bus.run = 1'b0;
    tick();
    chk("fin_release", bus.q, 0);
    chk("idle_iter_held", bus.iter_cnt, 2);

    // Limit 2, no match -> FIN with fail after 2nd check
    bus.iter_limit = 4'd2;
    bus.run = 1'b1;
    tick();
    chk("lim2_q", bus.q, 1);
    chk("lim2_iter_clr", bus.iter_cnt, 0);
    pulse_load(1'b1);
    pulse_load(1'b0);
    chk("lim2_back", bus.q, 1);
    chk("lim2_iter1", bus.iter_cnt, 1);
    pulse_load(1'b0);
    pulse_load(1'b0);
    chk("lim2_fin", bus.q, 3);
    chk("lim2_fail", bus.fail, 1);
    chk("lim2_iter2", bus.iter_cnt, 2);
    bus.run = 1'b0;
    tick();
    chk("lim2_idle", bus.q, 0);

    // Abort in IDLE with run=1: stays idle
    bus.run = 1'b1;
    bus.abort = 1'b1;
    tick();
    chk("idle_abort", bus.q, 0);
    bus.abort = 1'b0;
    tick();
    chk("start_after_abort", bus.q, 1);
    chk("start_fail_clr", bus.fail, 0);

    // Abort and load together in CHECK, iter_cnt nonzero
    pulse_load(1'b0);
    pulse_load(1'b0);
    pulse_load(1'b0);
    chk("ab_pre_q", bus.q, 2);
    chk("ab_pre_iter", bus.iter_cnt, 1);
    bus.abort = 1'b1;
    bus.load  = 1'b1;
    bus.match = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.load  = 1'b0;
    bus.match = 1'b0;
    chk("ab_q", bus.q, 0);
    chk("ab_iter", bus.iter_cnt, 0);
    chk("ab_fail", bus.fail, 0);

    // iter_limit=0 behaves as a single iteration
    bus.iter_limit = 4'd0;
    tick();
    chk("lim0_q", bus.q, 1);
    pulse_load(1'b0);
    pulse_load(1'b0);
    chk("lim0_fin", bus.q, 3);
    chk("lim0_fail", bus.fail, 1);
    chk("lim0_iter", bus.iter_cnt, 1);
    bus.run = 1'b0;
    tick();

    // run dropped while busy has no effect; abort in CHANGE
    bus.iter_limit = 4'd3;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    ticks(3);
    chk("run_drop_busy", bus.q, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("change_abort", bus.q, 0);

    // Timeout: ERR exactly 200 cycles after entering CHANGE
    bus.run = 1'b1;
    tick();
    chk("to_enter", bus.q, 1);
    ticks(TIMEOUT - 1);
    chk("to_edge_minus1", bus.q, 1);
    tick();
    chk("to_err", bus.q, 4);
    chk("to_fail", bus.fail, 1);
    chk("to_busy", bus.busy, 0);
    pulse_load(1'b1);
    chk("err_hold", bus.q, 4);
    bus.run = 1'b0;
    tick();
    chk("err_release", bus.q, 0);

    // Load in the last cycle beats timeout
    bus.run = 1'b1;
    tick();
    ticks(TIMEOUT - 1);
    pulse_load(1'b0);
    chk("to_load_q", bus.q, 2);
    chk("to_load_fail", bus.fail, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("check_abort", bus.q, 0);

    // Asynchronous reset mid-CHECK with iter_cnt=1
    tick();
    chk("rr_start", bus.q, 1);
    pulse_load(1'b0);
    pulse_load(1'b0);
    pulse_load(1'b0);
    chk("rr_pre_q", bus.q, 2);
    chk("rr_pre_iter", bus.iter_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_q", bus.q, 0);
    chk("rr_iter", bus.iter_cnt, 0);
    chk("rr_fail", bus.fail, 0);
    chk("rr_check_en", bus.check_en, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rr_restart", bus.q, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
